// File: rtl/demux_1x16_deser.sv
// demux_1x16_deser: serial-to-parallel word assembler.
// Each accepted bit is steered into one position of the output word. The
// position comes from sel (addressed mode) or from an internal counter
// (auto-increment mode). A written-mask tracks which positions have been
// filled. Once every position has been written, the word is held and
// flagged valid until the consumer takes it.
// Writing a position that is already filled overwrites its data and raises
// a one-cycle ovw pulse. IN_LENGTH must equal 2**SEL_LENGTH, so the counter
// wraps naturally at the word width.
module demux_1x16_deser #(
  parameter int IN_LENGTH  = 16,
  parameter int SEL_LENGTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_bit,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_LENGTH-1:0] sel,
  input  logic                  mode,
  output logic [IN_LENGTH-1:0]  out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  ovw
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IN_LENGTH-1:0]  out_q, out_d;
  logic [IN_LENGTH-1:0]  mask_q, mask_d;
  logic [SEL_LENGTH-1:0] cnt_q, cnt_d;
  logic                  ovw_q, ovw_d;
  logic [SEL_LENGTH-1:0] idx;
  logic                  accept;
  logic                  handoff;

  // Ready is withheld during reset so no bit can be counted as accepted in a
  // cycle whose effects reset will discard.
  assign in_ready  = (state_q == COLLECT) && !rst;
  assign accept    = in_valid && in_ready;
  assign handoff   = (state_q == HOLD) && out_ready;
  assign out       = out_q;
  assign out_valid = (state_q == HOLD);
  assign ovw       = ovw_q;

  // Next-state logic: steer accepted bits, track the mask, and clear
  // everything on handoff.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    ovw_d   = 1'b0;
    idx     = mode ? cnt_q : sel;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          out_d[idx] = in_bit;
          if (mask_q[idx]) begin
            ovw_d = 1'b1;
          end
          mask_d[idx] = 1'b1;
          // Only auto-increment accepts advance the counter; addressed
          // writes leave it where it was.
          if (mode) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (&mask_d) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (handoff) begin
          state_d = COLLECT;
          out_d   = '0;
          mask_d  = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State registers: reset overrides any concurrent accept or handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      out_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      ovw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      ovw_q   <= ovw_d;
    end
  end

endmodule

// File: tb/tb_demux_1x16_deser.sv
// Testbench for demux_1x16_deser: directed vector table, directed
// multi-cycle sequences and randomized traffic against a word-level model.
module tb_demux_1x16_deser;

  logic        clk;
  logic        rst;
  logic        in_bit;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  sel;
  logic        mode;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        ovw;

  demux_1x16_deser #(.IN_LENGTH(16), .SEL_LENGTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovw       (ovw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Word-level reference: which positions have been written, their values,
  // the running auto-increment position, and whether a full word is pending.
  bit m_word [16];
  bit m_seen [16];
  int m_nseen;
  int m_cnt;
  bit m_hold;
  bit m_ovw;

  // Most recent observed and predicted values.
  logic        act_rdy, act_ov, act_ovw;
  logic [15:0] act_out;
  logic        exp_rdy, exp_ov, exp_ovw;
  logic [15:0] exp_out;

  typedef struct {
    bit          r;
    bit          iv;
    bit          ib;
    logic [3:0]  s;
    bit          m;
    bit          orr;
    bit          e_rdy;
    logic [15:0] e_out;
    bit          e_ov;
    bit          e_ovw;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_word[i] = 1'b0;
      m_seen[i] = 1'b0;
    end
    m_nseen = 0;
    m_cnt   = 0;
    m_hold  = 1'b0;
    m_ovw   = 1'b0;
  endtask

  task automatic model_edge(input bit r, input bit iv, input bit ib, input logic [3:0] s,
                            input bit m, input bit orr);
    int idx;
    if (r) begin
      model_clear();
    end else if (m_hold) begin
      m_ovw = 1'b0;
      if (orr) model_clear();
    end else begin
      m_ovw = 1'b0;
      if (iv) begin
        idx = m ? m_cnt : int'(s);
        if (m_seen[idx]) m_ovw = 1'b1;
        else begin
          m_seen[idx] = 1'b1;
          m_nseen++;
        end
        m_word[idx] = ib;
        if (m) m_cnt = (m_cnt + 1) % 16;
        if (m_nseen == 16) m_hold = 1'b1;
      end
    end
    for (int i = 0; i < 16; i++) exp_out[i] = m_word[i];
    exp_ov  = m_hold;
    exp_ovw = m_ovw;
  endtask

  // One clock cycle: drive on the falling edge, sample ready before the
  // rising edge, advance the model, sample registered outputs after it.
  task automatic cycle(input bit r, input bit iv, input bit ib, input logic [3:0] s,
                       input bit m, input bit orr);
    @(negedge clk);
    rst       = r;
    in_valid  = iv;
    in_bit    = ib;
    sel       = s;
    mode      = m;
    out_ready = orr;
    #1;
    act_rdy = in_ready;
    exp_rdy = !m_hold && !r;
    @(posedge clk);
    model_edge(r, iv, ib, s, m, orr);
    #1;
    act_out = out;
    act_ov  = out_valid;
    act_ovw = ovw;
  endtask

  task automatic mstep(input bit r, input bit iv, input bit ib, input logic [3:0] s,
                       input bit m, input bit orr);
    cycle(r, iv, ib, s, m, orr);
    chk("in_ready", 32'(act_rdy), 32'(exp_rdy));
    chk("out", 32'(act_out), 32'(exp_out));
    chk("out_valid", 32'(act_ov), 32'(exp_ov));
    chk("ovw", 32'(act_ovw), 32'(exp_ovw));
  endtask

  initial begin
    logic [15:0] pat;
    logic [15:0] mixed;
    bit          b;

    rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; sel = 4'd0; mode = 1'b0; out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);

    // Reset state and short directed vectors with hand-computed expectations.
    //              r  iv ib sel   m  or  rdy out       ov ovw
    tbl[0]  = '{1'b1,1'b1,1'b1,4'd0, 1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b1,4'd3, 1'b0,1'b0, 1'b1,16'h0008,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b0,4'd3, 1'b0,1'b0, 1'b1,16'h0000,1'b0,1'b1};
    tbl[3]  = '{1'b0,1'b0,1'b0,4'd0, 1'b0,1'b0, 1'b1,16'h0000,1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b1,1'b1,4'd5, 1'b1,1'b0, 1'b1,16'h0001,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b1,1'b1,4'd9, 1'b1,1'b0, 1'b1,16'h0003,1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b1,1'b1,4'd1, 1'b0,1'b0, 1'b1,16'h0003,1'b0,1'b1};
    tbl[7]  = '{1'b0,1'b1,1'b0,4'd0, 1'b1,1'b0, 1'b1,16'h0003,1'b0,1'b0};
    tbl[8]  = '{1'b1,1'b1,1'b1,4'd7, 1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b1,4'd6, 1'b1,1'b0, 1'b1,16'h0001,1'b0,1'b0};
    tbl[10] = '{1'b1,1'b0,1'b0,4'd0, 1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b0};
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].r, tbl[i].iv, tbl[i].ib, tbl[i].s, tbl[i].m, tbl[i].orr);
      chk($sformatf("vec%0d.in_ready", i), 32'(act_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d.out", i), 32'(act_out), 32'(tbl[i].e_out));
      chk($sformatf("vec%0d.out_valid", i), 32'(act_ov), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d.ovw", i), 32'(act_ovw), 32'(tbl[i].e_ovw));
    end

    // Serial fill 0xA5C3 LSB-first.
    pat = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      mstep(1'b0, 1'b1, pat[i], 4'd0, 1'b1, 1'b0);
      if (i < 15) chk("serial.no_early_valid", 32'(act_ov), 32'd0);
    end
    chk("serial.out", 32'(act_out), 32'hA5C3);
    chk("serial.out_valid", 32'(act_ov), 32'd1);

    // Backpressure in HOLD with in_valid asserted; then handoff and bubble.
    for (int i = 0; i < 5; i++) begin
      mstep(1'b0, 1'b1, 1'($urandom), 4'($urandom), 1'($urandom), 1'b0);
      chk("hold.ready_low", 32'(act_rdy), 32'd0);
      chk("hold.stable", 32'(act_out), 32'hA5C3);
    end
    mstep(1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
    chk("handoff.out", 32'(act_out), 32'h0000);
    chk("handoff.out_valid", 32'(act_ov), 32'd0);
    mstep(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("bubble.ready_back", 32'(act_rdy), 32'd1);

    // Addressed fill, sel 15 down to 0; only ends set.
    for (int i = 15; i >= 0; i--) begin
      mstep(1'b0, 1'b1, (i == 0 || i == 15), 4'(i), 1'b0, 1'b0);
    end
    chk("addr.out", 32'(act_out), 32'h8001);
    chk("addr.out_valid", 32'(act_ov), 32'd1);
    // out_ready already high at entry to HOLD: word held exactly one cycle.
    mstep(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("addr.one_cycle", 32'(act_ov), 32'd0);

    // Reset after 9 serial accepts, then a full 0xFFFF word.
    for (int i = 0; i < 9; i++) mstep(1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
    mstep(1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
    chk("rst_mid.out", 32'(act_out), 32'h0000);
    for (int i = 0; i < 16; i++) mstep(1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
    chk("rst_mid.full", 32'(act_out), 32'hFFFF);
    chk("rst_mid.valid", 32'(act_ov), 32'd1);

    // Reset while holding drops the word.
    mstep(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("rst_hold.valid", 32'(act_ov), 32'd0);
    chk("rst_hold.out", 32'(act_out), 32'h0000);

    // Mixed modes: 8 auto-increment then sel 8..15 addressed.
    mixed = 16'($urandom);
    for (int i = 0; i < 8; i++) mstep(1'b0, 1'b1, mixed[i], 4'd15, 1'b1, 1'b0);
    for (int i = 8; i < 16; i++) begin
      mstep(1'b0, 1'b1, mixed[i], 4'(i), 1'b0, 1'b0);
      if (i < 15) chk("mixed.no_early_valid", 32'(act_ov), 32'd0);
    end
    chk("mixed.out", 32'(act_out), 32'(mixed));
    chk("mixed.valid", 32'(act_ov), 32'd1);
    mstep(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    // After handoff the counter restarts at 0: a mode-1 accept lands in bit 0.
    mstep(1'b0, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
    chk("mixed.cnt_cleared", 32'(act_out), 32'h0001);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      b = ($urandom_range(0, 59) == 0);
      mstep(b, ($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
            ($urandom_range(0, 2) != 0), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1x16_deser.md
DEMUX_1X16_DESER -- requirements
Module: demux_1x16_deser

Interface
REQ-001 Parameter IN_LENGTH, default 16, SHALL set the assembled word width and the number of demux outputs.
REQ-002 Parameter SEL_LENGTH, default 4, SHALL set the bit-index width, with IN_LENGTH == 2**SEL_LENGTH.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, which is synchronous and active-high.
REQ-005 in_bit  input  1  SHALL carry the serial data bit to be steered into the word.
REQ-006 in_valid  input  1  SHALL indicate that in_bit, sel and mode are valid.
REQ-007 in_ready  output  1  SHALL indicate that the block accepts a bit this cycle.
REQ-008 sel  input  SEL_LENGTH  SHALL give the destination bit index in addressed mode.
REQ-009 mode  input  1  SHALL select the index source per accepted bit: 0 = addressed (sel), 1 = auto-increment (internal counter).
REQ-010 out  output  IN_LENGTH  SHALL present the assembled word.
REQ-011 out_valid  output  1  SHALL indicate that out holds a complete word.
REQ-012 out_ready  input  1  SHALL indicate that the consumer takes the word.
REQ-013 ovw  output  1  SHALL pulse for one cycle when an accepted bit overwrites an already-written index.

Function
REQ-014 The FSM SHALL have two states: COLLECT and HOLD.
REQ-015 in_ready SHALL be 1 iff state == COLLECT and rst == 0; in HOLD, in_ready SHALL be 0.
REQ-016 A bit SHALL be accepted iff in_valid && in_ready.
REQ-017 The destination index idx SHALL be sel when mode == 0 and cnt when mode == 1, with mode evaluated on every accepted bit.
REQ-018 On accept, the block SHALL write in_bit to out[idx] on the next edge and leave all other out bits unchanged.
REQ-019 On accept, the block SHALL set written-mask bit mask[idx].
REQ-020 cnt (SEL_LENGTH bits) SHALL increment modulo IN_LENGTH only on accepts with mode == 1; mode-0 accepts SHALL leave cnt unchanged.
REQ-021 When an accept hits an index whose mask bit is already 1, the block SHALL overwrite the data, leave the mask unchanged, and assert ovw on the next cycle for exactly one cycle.
REQ-022 When an accept makes the mask all-ones, the FSM SHALL enter HOLD on the same edge.
REQ-023 In HOLD, out_valid SHALL be 1 from the cycle after the final distinct bit is accepted (latency 1).
REQ-024 In HOLD, out SHALL remain stable until handoff.
REQ-025 Handoff SHALL occur when out_valid && out_ready.
REQ-026 On handoff, the FSM SHALL return to COLLECT on the next edge with out = 0, mask = 0, cnt = 0 and out_valid = 0.
REQ-027 There SHALL be exactly one bubble cycle between handoff and the next accept: in_ready returns the cycle after handoff.
REQ-028 out_valid SHALL be 0 in COLLECT; partial words SHALL never be flagged valid.
REQ-029 If out_ready is held high in HOLD, the word SHALL be held for exactly one cycle.
REQ-030 in_valid asserted during HOLD SHALL be ignored: no write, no mask change, no cnt change.
REQ-031 Mixed modes within one word SHALL be legal, and completion SHALL depend only on the mask.

Reset
REQ-032 When rst == 1 at a rising edge, the block SHALL set state = COLLECT, out = 0, mask = 0, cnt = 0, out_valid = 0 and ovw = 0, regardless of any concurrent accept or handoff.
REQ-033 in_ready SHALL be 0 in any cycle where rst == 1.
REQ-034 Reset mid-word SHALL discard all partial data.
REQ-035 Reset in HOLD SHALL drop the pending word without a handoff.
REQ-036 The first accept SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-037 Serial fill: rst then mode = 1, in_valid = 1 for 16 cycles with in_bit pattern of 0xA5C3 LSB-first -> out_valid = 1 on cycle 17, out = 0xA5C3, in_ready = 0.
REQ-038 Addressed fill: mode = 0, sel = 15 down to 0, in_bit = 1 only for sel = 0 and sel = 15 -> out = 0x8001, out_valid = 1 the cycle after the 16th accept.
REQ-039 Overwrite: mode = 0, write sel = 3 with bit 1, then sel = 3 with bit 0 -> ovw = 1 for one cycle, out[3] = 0, no completion until the other 15 indices are written.
REQ-040 Backpressure and bubble: hold out_ready = 0 for 5 cycles in HOLD with in_valid = 1 -> out stable, no writes; then out_ready = 1 -> next cycle out = 0, out_valid = 0, in_ready = 1.
REQ-041 Reset mid-operation: assert rst after 9 serial accepts -> next cycle out = 0, cnt = 0; then a full 16-bit serial word of 0xFFFF -> out = 0xFFFF after exactly 16 accepts.
REQ-042 Mixed mode: mode-1 accepts for indices 0-7, then mode-0 writes with sel = 8..15 -> completion on the 16th accept, cnt = 8 before the handoff clears it.
